serv_irq_csr: RTL and testbench
===============================

# serv_irq_csr

Bit-serial machine-mode CSR and interrupt unit for the SERV core, the parametrised successor of the single-timer CSR block. It holds mstatus.MIE/MPIE, an NIRQ-bit mie, a read-only mip, and a 6-bit compressed mcause. It prioritises NIRQ interrupt lines into a cause code and exchanges CSR data one bit per cycle with the state/decode logic and the register-file CSR storage.

## Interface
Parameters:
- NIRQ, 3, number of interrupt lines, legal 3..19. Line 0 is MSI (bit 3), line 1 is MTI (bit 7), line 2 is MEI (bit 11), line k≥3 is platform bit 16+(k-3).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  serial transfer active
- i_cnt  in  3  [4:2], current nibble of the 32-cycle transfer
- i_cnt_r  in  4  one-hot bit within the nibble; bit index = 4*i_cnt + log2(i_cnt_r)
- i_e_op, i_ebreak, i_mem_cmd, i_mem_misalign  in  1 each  exception qualifiers
- i_rf_csr_out  in  1  serial CSR data from register file (mscratch/mepc/mtval/mtvec)
- o_csr_in  out  1  serial write data to register file
- i_irq  in  NIRQ  level interrupt requests
- o_new_irq  out  1  one-cycle pulse, new enabled interrupt pending
- o_irq_pending  out  1  level, some enabled interrupt pending
- i_trap_taken, i_mret  in  1 each  trap entry / return strobes
- i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en  in  1 each  CSR select, at most one high
- i_csr_source  in  2  00 CSR, 01 EXT, 10 SET, 11 CLR
- i_d  in  1  serial operand
- o_q  out  1  serial read data

## Operation
- csr_in: EXT=i_d; SET=csr_out|i_d; CLR=csr_out&~i_d; CSR=csr_out.
- csr_out = OR of i_rf_csr_out and the selected internal CSR bit, gated by i_en. Unimplemented bits read 0.
- mstatus: bit 3 is MIE, bit 7 is MPIE (see Configuration). Write MIE at index 3 when i_mstatus_en&i_en.
- mie: NIRQ flops at the mapped bit indices. Each is written from csr_in at its index when i_mie_en&i_en.
- mip: mip_r <= i_irq every cycle. Reads at mapped indices. Writes are ignored.
- pend_vec = mip_r & mie & {NIRQ{MIE}}. o_irq_pending = |pend_vec. pend_r <= o_irq_pending. o_new_irq = o_irq_pending & ~pend_r.
- Priority, highest first: platform lines (highest k first), MEI, MSI, MTI. The winner's bit number is cause_sel[4:0].
- mcause storage: flag (bit 31) plus code[4:0] (bits 0..4). Other bits read 0.
- mcause serial access: code shifts LSB-first at indices 0..4 when i_mcause_en&i_en. The flag is written at index 31.
- On i_trap_taken:
  - MPIE<=MIE, MIE<=0.
  - If o_irq_pending: flag=1, code=cause_sel.
  - Else flag=0, and code is, in priority order:
    - i_e_op: {!i_ebreak,3'b011} (3 for ebreak, 11 for ecall)
    - i_mem_misalign: {2'b01,i_mem_cmd,1'b0} (4 for load, 6 for store)
    - otherwise 0.
- On i_mret: MIE<=MPIE, MPIE<=1.
- Precedence in one cycle: i_rst > i_trap_taken > i_mret > serial write.

## Timing
- Reset values are all 0: MIE, MPIE, mie, mip_r, pend_r, mcause, o_new_irq, o_irq_pending.
- i_irq sampled at edge k:
  - o_irq_pending is high after edge k, provided it is enabled.
  - o_new_irq is high for exactly the cycle between edges k and k+1.
- Irq held with MIE cleared, then MIE set: a new pulse follows the edge that sets MIE.
- Serial read: o_q is valid combinationally in the cycle of its bit index. Writes land at the end of that cycle.
- A transfer is 32 cycles. Reset mid-transfer aborts it; state returns to reset values.
- Trap/mret strobes take effect at the next edge with no wait. They must not coincide with an mcause transfer.

## Configuration
- SERV_CSR_MPIE_RW_EN defined:
  - MPIE reads at mstatus bit 7.
  - MPIE is writable from csr_in at index 7.
- Undefined:
  - Bit 7 reads 0 and writes are ignored.
  - MPIE is still updated by trap and mret.

## Test plan
- Reset, then read mstatus, mie, mip, mcause → all 32 serial bits 0; o_new_irq=0.
- NIRQ=5:
  - EXT-write mie=0x00030888 and mstatus=0x8.
  - Raise i_irq=5'b00010 → one o_new_irq pulse.
  - Trap → mcause reads 0x80000007 and MIE reads 0.
- All lines raised with all enables set, then trap → mcause=0x80000011 (line 4, bit 17). Drop line 4, trap again → 0x80000010.
- ecall trap → 0x0000000B. ebreak → 0x3. Misaligned store → 0x6. Misaligned load → 0x4. All with flag 0.
- Trap with MIE=1, then mret → MIE=1 and MPIE=1. With SERV_CSR_MPIE_RW_EN, mstatus reads 0x88.
- Trap and mret in the same cycle → trap wins: MIE=0. SET mip=0xFFFFFFFF → mip unchanged.

Source files
------------

// File: rtl/serv_irq_csr.sv
`default_nettype none
// ============================================================================
// Module      : serv_irq_csr
// Description : Bit-serial M-mode CSR/interrupt unit (mstatus, mie, mip,
//               mcause) with NIRQ prioritised interrupt lines.
//               Optional: SERV_CSR_MPIE_RW_EN makes mstatus.MPIE (bit 7) R/W.
// Revision    : 1.0 - initial release
// ============================================================================
module serv_irq_csr #(
    parameter int NIRQ = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [2:0]      i_cnt,
    input  logic [3:0]      i_cnt_r,
    input  logic            i_e_op,
    input  logic            i_ebreak,
    input  logic            i_mem_cmd,
    input  logic            i_mem_misalign,
    input  logic            i_rf_csr_out,
    output logic            o_csr_in,
    input  logic [NIRQ-1:0] i_irq,
    output logic            o_new_irq,
    output logic            o_irq_pending,
    input  logic            i_trap_taken,
    input  logic            i_mret,
    input  logic            i_mstatus_en,
    input  logic            i_mie_en,
    input  logic            i_mip_en,
    input  logic            i_mcause_en,
    input  logic [1:0]      i_csr_source,
    input  logic            i_d,
    output logic            o_q
);

    localparam logic [1:0] c_src_csr = 2'b00;
    localparam logic [1:0] c_src_ext = 2'b01;
    localparam logic [1:0] c_src_set = 2'b10;

    // mip/mie bit number of interrupt line k
    function automatic logic [4:0] f_irq_bit(input int k);
        if (k == 0)      return 5'd3;
        else if (k == 1) return 5'd7;
        else if (k == 2) return 5'd11;
        else             return 5'(13 + k);
    endfunction

    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic [NIRQ-1:0] r_mie;
    logic [NIRQ-1:0] r_mip;
    logic            r_pend;
    logic            r_mcause_flag;
    logic [4:0]      r_mcause_code;

    logic            w_en;
    logic [4:0]      w_idx;
    logic [NIRQ-1:0] w_hit;
    logic [NIRQ-1:0] w_pend_vec;
    logic            w_mpie_rd;
    logic            w_csr_rd;
    logic            w_csr_out;
    logic            w_csr_in;
    logic [4:0]      w_cause_sel;
    logic [4:0]      w_exc_code;

    assign w_en  = i_en & (|i_cnt_r);
    assign w_idx = {i_cnt, i_cnt_r[3] | i_cnt_r[2], i_cnt_r[3] | i_cnt_r[1]};

    for (genvar k = 0; k < NIRQ; k++) begin : g_line
        assign w_hit[k] = (w_idx == f_irq_bit(k));
    end

`ifdef SERV_CSR_MPIE_RW_EN
    assign w_mpie_rd = (w_idx == 5'd7) & r_mstatus_mpie;
`else
    assign w_mpie_rd = 1'b0;
`endif

    // mcause code is a shift register: bit 0 is always the one on the wire
    assign w_csr_rd = (i_mstatus_en & (((w_idx == 5'd3) & r_mstatus_mie) | w_mpie_rd))
                    | (i_mie_en & (|(r_mie & w_hit)))
                    | (i_mip_en & (|(r_mip & w_hit)))
                    | (i_mcause_en & (((w_idx < 5'd5) & r_mcause_code[0])
                                    | ((w_idx == 5'd31) & r_mcause_flag)));

    assign w_csr_out = (i_rf_csr_out | w_csr_rd) & i_en;

    always_comb begin
        case (i_csr_source)
            c_src_csr: w_csr_in = w_csr_out;
            c_src_ext: w_csr_in = i_d;
            c_src_set: w_csr_in = w_csr_out | i_d;
            default:   w_csr_in = w_csr_out & ~i_d;
        endcase
    end

    assign o_csr_in = w_csr_in;
    assign o_q      = w_csr_out;

    assign w_pend_vec    = r_mip & r_mie & {NIRQ{r_mstatus_mie}};
    assign o_irq_pending = |w_pend_vec;
    assign o_new_irq     = o_irq_pending & ~r_pend;

    // Later assignments override: lowest priority first
    always_comb begin
        w_cause_sel = 5'd0;
        if (w_pend_vec[1]) w_cause_sel = f_irq_bit(1);
        if (w_pend_vec[0]) w_cause_sel = f_irq_bit(0);
        if (w_pend_vec[2]) w_cause_sel = f_irq_bit(2);
        for (int k = 3; k < NIRQ; k++) begin
            if (w_pend_vec[k]) w_cause_sel = f_irq_bit(k);
        end
    end

    always_comb begin
        if (i_e_op)              w_exc_code = {1'b0, ~i_ebreak, 3'b011};
        else if (i_mem_misalign) w_exc_code = {3'b001, i_mem_cmd, 1'b0};
        else                     w_exc_code = 5'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mip          <= '0;
            r_pend         <= 1'b0;
            r_mcause_flag  <= 1'b0;
            r_mcause_code  <= 5'd0;
        end else begin
            r_mip  <= i_irq;
            r_pend <= o_irq_pending;

            if (i_trap_taken) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_mcause_flag  <= o_irq_pending;
                r_mcause_code  <= o_irq_pending ? w_cause_sel : w_exc_code;
            end else if (i_mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else begin
                if (i_mstatus_en & w_en & (w_idx == 5'd3))
                    r_mstatus_mie <= w_csr_in;
`ifdef SERV_CSR_MPIE_RW_EN
                if (i_mstatus_en & w_en & (w_idx == 5'd7))
                    r_mstatus_mpie <= w_csr_in;
`endif
                if (i_mcause_en & w_en & (w_idx < 5'd5))
                    r_mcause_code <= {w_csr_in, r_mcause_code[4:1]};
                if (i_mcause_en & w_en & (w_idx == 5'd31))
                    r_mcause_flag <= w_csr_in;
            end

            for (int k = 0; k < NIRQ; k++) begin
                if (i_mie_en & w_en & w_hit[k])
                    r_mie[k] <= w_csr_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serv_irq_csr.sv
`default_nettype none
// Directed bench for serv_irq_csr (NIRQ=5) with an expected-value queue.
module tb_serv_irq_csr;

    localparam int NIRQ = 5;
    localparam logic [3:0] SEL_MSTATUS = 4'b0001;
    localparam logic [3:0] SEL_MIE     = 4'b0010;
    localparam logic [3:0] SEL_MIP     = 4'b0100;
    localparam logic [3:0] SEL_MCAUSE  = 4'b1000;
`ifdef SERV_CSR_MPIE_RW_EN
    localparam logic [31:0] MPIE_BIT      = 32'h0000_0080;
    localparam logic [31:0] EXP_CLR_MRET  = 32'h0000_0080;
`else
    localparam logic [31:0] MPIE_BIT      = 32'h0000_0000;
    localparam logic [31:0] EXP_CLR_MRET  = 32'h0000_0008;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_en = 1'b0;
    logic [2:0]      i_cnt = 3'd0;
    logic [3:0]      i_cnt_r = 4'd0;
    logic            i_e_op = 1'b0, i_ebreak = 1'b0, i_mem_cmd = 1'b0, i_mem_misalign = 1'b0;
    logic            i_rf_csr_out = 1'b0;
    logic            o_csr_in;
    logic [NIRQ-1:0] i_irq = '0;
    logic            o_new_irq, o_irq_pending;
    logic            i_trap_taken = 1'b0, i_mret = 1'b0;
    logic            i_mstatus_en = 1'b0, i_mie_en = 1'b0, i_mip_en = 1'b0, i_mcause_en = 1'b0;
    logic [1:0]      i_csr_source = 2'b00;
    logic            i_d = 1'b0;
    logic            o_q;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd;

    serv_irq_csr #(.NIRQ(NIRQ)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(i_en), .i_cnt(i_cnt), .i_cnt_r(i_cnt_r),
        .i_e_op(i_e_op), .i_ebreak(i_ebreak), .i_mem_cmd(i_mem_cmd),
        .i_mem_misalign(i_mem_misalign), .i_rf_csr_out(i_rf_csr_out),
        .o_csr_in(o_csr_in), .i_irq(i_irq), .o_new_irq(o_new_irq),
        .o_irq_pending(o_irq_pending), .i_trap_taken(i_trap_taken), .i_mret(i_mret),
        .i_mstatus_en(i_mstatus_en), .i_mie_en(i_mie_en), .i_mip_en(i_mip_en),
        .i_mcause_en(i_mcause_en), .i_csr_source(i_csr_source), .i_d(i_d), .o_q(o_q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic xfer(input logic [3:0] sel, input logic [1:0] src,
                        input logic [31:0] d, output logic [31:0] q);
        for (int i = 0; i < 32; i++) begin
            i_en = 1'b1;
            i_cnt = 3'(i >> 2);
            i_cnt_r = 4'(1 << (i % 4));
            i_d = d[i];
            {i_mcause_en, i_mip_en, i_mie_en, i_mstatus_en} = sel;
            i_csr_source = src;
            @(negedge clk);
            q[i] = o_q;
            tick();
        end
        i_en = 1'b0;
        i_cnt = 3'd0;
        i_cnt_r = 4'd0;
        i_d = 1'b0;
        {i_mcause_en, i_mip_en, i_mie_en, i_mstatus_en} = 4'b0000;
        i_csr_source = 2'b00;
    endtask

    task automatic read_csr(input string tag, input logic [3:0] sel, input logic [31:0] exp);
        logic [31:0] q;
        exp_q.push_back(exp);
        xfer(sel, 2'b00, 32'h0, q);
        check(tag, q);
    endtask

    task automatic write_csr(input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] q;
        xfer(sel, 2'b01, d, q);
    endtask

    task automatic strobe(input logic trap, input logic mret, input logic eop,
                          input logic ebrk, input logic cmd, input logic mis);
        i_trap_taken = trap; i_mret = mret; i_e_op = eop;
        i_ebreak = ebrk; i_mem_cmd = cmd; i_mem_misalign = mis;
        tick();
        i_trap_taken = 1'b0; i_mret = 1'b0; i_e_op = 1'b0;
        i_ebreak = 1'b0; i_mem_cmd = 1'b0; i_mem_misalign = 1'b0;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        exp_q.push_back({31'd0, exp});
        check(tag, {31'd0, obs});
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check_bit("rst_new_irq", o_new_irq, 1'b0);
        check_bit("rst_pending", o_irq_pending, 1'b0);
        read_csr("rst_mstatus", SEL_MSTATUS, 32'h0);
        read_csr("rst_mie", SEL_MIE, 32'h0);
        read_csr("rst_mip", SEL_MIP, 32'h0);
        read_csr("rst_mcause", SEL_MCAUSE, 32'h0);

        write_csr(SEL_MIE, 32'hFFFF_FFFF);
        read_csr("mie_mapped", SEL_MIE, 32'h0003_0888);
        write_csr(SEL_MSTATUS, 32'h0000_0008);
        read_csr("mstatus_mie", SEL_MSTATUS, 32'h0000_0008);

        // MTI only: single new-irq pulse
        i_irq = 5'b00010;
        tick();
        check_bit("new_irq_pulse", o_new_irq, 1'b1);
        check_bit("pending_high", o_irq_pending, 1'b1);
        tick();
        check_bit("new_irq_drop", o_new_irq, 1'b0);
        check_bit("pending_hold", o_irq_pending, 1'b1);

        strobe(1, 0, 0, 0, 0, 0);
        read_csr("mcause_mti", SEL_MCAUSE, 32'h8000_0007);
        read_csr("mstatus_trap", SEL_MSTATUS, MPIE_BIT);
        check_bit("pending_masked", o_irq_pending, 1'b0);

        i_irq = 5'b11111;
        strobe(0, 1, 0, 0, 0, 0);
        strobe(1, 0, 0, 0, 0, 0);
        read_csr("mcause_line4", SEL_MCAUSE, 32'h8000_0011);
        i_irq = 5'b01111;
        strobe(0, 1, 0, 0, 0, 0);
        strobe(1, 0, 0, 0, 0, 0);
        read_csr("mcause_line3", SEL_MCAUSE, 32'h8000_0010);
        i_irq = 5'b00111;
        strobe(0, 1, 0, 0, 0, 0);
        strobe(1, 0, 0, 0, 0, 0);
        read_csr("mcause_mei", SEL_MCAUSE, 32'h8000_000B);
        i_irq = 5'b00011;
        strobe(0, 1, 0, 0, 0, 0);
        strobe(1, 0, 0, 0, 0, 0);
        read_csr("mcause_msi", SEL_MCAUSE, 32'h8000_0003);

        i_irq = 5'b00000;
        tick();
        strobe(1, 0, 1, 0, 0, 0);
        read_csr("mcause_ecall", SEL_MCAUSE, 32'h0000_000B);
        strobe(1, 0, 1, 1, 0, 0);
        read_csr("mcause_ebreak", SEL_MCAUSE, 32'h0000_0003);
        strobe(1, 0, 0, 0, 1, 1);
        read_csr("mcause_store_mis", SEL_MCAUSE, 32'h0000_0006);
        strobe(1, 0, 0, 0, 0, 1);
        read_csr("mcause_load_mis", SEL_MCAUSE, 32'h0000_0004);
        write_csr(SEL_MCAUSE, 32'hFFFF_FFFF);
        read_csr("mcause_write", SEL_MCAUSE, 32'h8000_001F);

        // MPIE=1, then clear mstatus: MPIE survives only when not writable
        strobe(0, 1, 0, 0, 0, 0);
        write_csr(SEL_MSTATUS, 32'h0000_0000);
        strobe(0, 1, 0, 0, 0, 0);
        read_csr("mstatus_mpie_wr", SEL_MSTATUS, EXP_CLR_MRET);

        write_csr(SEL_MSTATUS, 32'h0000_0008);
        strobe(1, 0, 0, 0, 0, 0);
        strobe(0, 1, 0, 0, 0, 0);
        read_csr("mstatus_mret", SEL_MSTATUS, 32'h0000_0008 | MPIE_BIT);
        strobe(1, 1, 0, 0, 0, 0);
        read_csr("mstatus_trap_wins", SEL_MSTATUS, MPIE_BIT);

        i_irq = 5'b00101;
        tick();
        exp_q.push_back(32'h0000_0808);
        xfer(SEL_MIP, 2'b10, 32'hFFFF_FFFF, rd);
        check("mip_set_rd", rd);
        read_csr("mip_unchanged", SEL_MIP, 32'h0000_0808);

        // Reset in the middle of an mie write
        i_irq = 5'b00000;
        for (int i = 0; i < 10; i++) begin
            i_en = 1'b1; i_mie_en = 1'b1; i_csr_source = 2'b01; i_d = 1'b1;
            i_cnt = 3'(i >> 2);
            i_cnt_r = 4'(1 << (i % 4));
            if (i == 9) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        i_en = 1'b0; i_mie_en = 1'b0; i_csr_source = 2'b00; i_d = 1'b0;
        i_cnt = 3'd0; i_cnt_r = 4'd0;
        check_bit("midrst_pending", o_irq_pending, 1'b0);
        read_csr("midrst_mie", SEL_MIE, 32'h0);
        read_csr("midrst_mstatus", SEL_MSTATUS, 32'h0);
        read_csr("midrst_mcause", SEL_MCAUSE, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
